skid_fifo: RTL and testbench

- Parametrised successor to the single-entry skid buffer: an elastic valid/ready buffer of configurable width and depth.
- Both o_ready and o_valid/o_data are fully registered, so no combinational path crosses the block in either direction.
- Adds occupancy count, an almost-full flag and a synchronous flush.
- Sits between pipeline stages where the downstream stage may stall for bursts longer than one cycle.

---
 rtl/skid_pkg.sv | 35 +++
 rtl/skid_fifo_mem.sv | 40 ++++
 rtl/skid_fifo.sv | 168 ++++++++++++++++
 tb/tb_skid_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : skid_pkg
//  Description : Shared helpers for the skid_fifo elastic buffer. Provides the
//                width functions used to size the occupancy counter and the
//                storage pointers, plus the parameter legality predicate that
//                the top level evaluates at elaboration time.
//  Ports       : (package - none)
//  Revision    : 1.0  initial release
// ============================================================================
package skid_pkg;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer into the storage array. The array has depth-1
    // entries, but the pointer is sized from depth so it is never 0 bits wide.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // DEPTH must be a power of two of at least 2; AF_MARGIN in 0..DEPTH-1.
    function automatic bit params_legal(input int depth, input int af_margin);
        return is_pow2(depth) && (depth >= 2) &&
               (af_margin >= 0) && (af_margin < depth);
    endfunction

endpackage : skid_pkg
`default_nettype wire

// File: rtl/skid_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo_mem
//  Description : DW x ENTRIES register array behind the skid_fifo output
//                register. One synchronous write port, one combinational read
//                of the entry addressed by the read pointer (the FIFO head).
//  Ports       : i_clk    - clock, rising edge
//                i_we     - write enable
//                i_waddr  - write address (tail pointer)
//                i_wdata  - write data
//                i_raddr  - read address (head pointer)
//                o_rdata  - head entry, combinational
//  Revision    : 1.0  initial release
// ============================================================================
module skid_fifo_mem #(
    parameter int DW      = 8,
    parameter int ENTRIES = 3,
    parameter int AW      = 2
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Contents need no reset: an entry is only read after it has been written.
    logic [DW-1:0] mem_q [ENTRIES];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : skid_fifo_mem
`default_nettype wire

// File: rtl/skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo
//  Description : Elastic valid/ready buffer of DEPTH entries. The output
//                register counts as one entry; the remaining DEPTH-1 live in
//                a circular register array. o_ready, o_valid, o_data, o_count
//                and o_almost_full are all registered, so no combinational
//                path crosses the block. Synchronous flush discards contents.
//  Ports       : i_clk          - clock, rising edge
//                i_reset_n      - synchronous active-low reset
//                i_flush        - synchronous discard of all contents
//                i_valid/o_ready/i_data   - upstream handshake
//                o_valid/i_ready/o_data   - downstream handshake
//                o_count        - occupancy including the output register
//                o_almost_full  - o_count >= DEPTH-AF_MARGIN
//  Revision    : 1.0  initial release
// ============================================================================
module skid_fifo
    import skid_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DW-1:0]               i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DW-1:0]               o_data,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    output logic                        o_almost_full
);

    localparam int CW      = cnt_width(DEPTH);
    localparam int AW      = ptr_width(DEPTH);
    localparam int ENTRIES = DEPTH - 1;

    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF_LEVEL = CW'(DEPTH - AF_MARGIN);
    localparam logic [AW-1:0] C_PTR_LAST = AW'(DEPTH - 2);

    if (!params_legal(DEPTH, AF_MARGIN)) begin : g_param_check
        $error("skid_fifo: DEPTH must be a power of two >= 2 and AF_MARGIN < DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          valid_q,  valid_d;
    logic [DW-1:0] data_q,   data_d;
    logic          ready_q,  ready_d;
    logic          af_q,     af_d;
    logic [CW-1:0] count_q,  count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    logic          w_accept;
    logic          w_pop;
    logic          w_load_out;
    logic          w_store_nonempty;
    logic          w_mem_we;
    logic [DW-1:0] w_head;

    // Storage has DEPTH-1 slots, which is not a power of two, so the wrap
    // point is compared explicitly instead of relying on pointer overflow.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign w_accept   = i_valid && ready_q;
    assign w_pop      = valid_q && i_ready;
    assign w_load_out = !valid_q || i_ready;

    // Words in storage = count minus the one held in the output register.
    assign w_store_nonempty = (count_q != {{(CW-1){1'b0}}, valid_q});

    // An accepted word may only bypass into the output register when storage
    // is empty and the register is free this cycle; otherwise it is queued
    // behind older words to preserve order.
    assign w_mem_we = i_reset_n && !i_flush && w_accept &&
                      ((valid_q && !i_ready) || w_store_nonempty);

    skid_fifo_mem #(
        .DW      (DW),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (w_head)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (i_flush) begin
            // o_data deliberately keeps its value; only validity is dropped.
            valid_d  = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_load_out) begin
                if (w_store_nonempty) begin
                    valid_d  = 1'b1;
                    data_d   = w_head;
                    rd_ptr_d = next_ptr(rd_ptr_q);
                end else if (w_accept) begin
                    valid_d  = 1'b1;
                    data_d   = i_data;
                end else begin
                    valid_d  = 1'b0;
                end
            end
            if (w_mem_we) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            count_d = count_q + CW'(w_accept) - CW'(w_pop);
        end

        // Flags derive from the next count so they are registered, yet let
        // o_ready recover on the very edge that frees a slot.
        ready_d = (count_d < C_DEPTH);
        af_d    = (count_d >= C_AF_LEVEL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            af_q     <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            af_q     <= af_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_data        = data_q;
    assign o_ready       = ready_q;
    assign o_almost_full = af_q;
    assign o_count       = count_q;

endmodule : skid_fifo
`default_nettype wire

// File: tb/tb_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skid_fifo
//  Description : Self-checking bench for skid_fifo. Directed vectors on a
//                DEPTH=4 instance plus scoreboarded random traffic on DEPTH=2
//                and DEPTH=8 instances.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_skid_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Directed DUT: DEPTH=4, AF_MARGIN=1
    // ------------------------------------------------------------------
    logic       d_rst_n, d_flush, d_valid, d_oready, d_ovalid, d_iready, d_af;
    logic [7:0] d_data, d_odata;
    logic [2:0] d_count;

    skid_fifo #(.DW(8), .DEPTH(4), .AF_MARGIN(1)) u_dut (
        .i_clk         (clk),
        .i_reset_n     (d_rst_n),
        .i_flush       (d_flush),
        .i_valid       (d_valid),
        .o_ready       (d_oready),
        .i_data        (d_data),
        .o_valid       (d_ovalid),
        .i_ready       (d_iready),
        .o_data        (d_odata),
        .o_count       (d_count),
        .o_almost_full (d_af)
    );

    typedef struct packed {
        logic       flush;
        logic       valid;
        logic       ready;
        logic [7:0] data;
        logic       ev;
        logic       er;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       eaf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic f, input logic v, input logic r,
                                input logic [7:0] d, input logic ev,
                                input logic er, input logic [7:0] ed,
                                input logic [2:0] ec, input logic eaf);
        vec_t t;
        t = {f, v, r, d, ev, er, ed, ec, eaf};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic er,
                             input logic [7:0] ed, input logic [2:0] ec,
                             input logic eaf);
        chk({tag, ".o_valid"},       32'(d_ovalid), 32'(ev));
        chk({tag, ".o_ready"},       32'(d_oready), 32'(er));
        chk({tag, ".o_data"},        32'(d_odata),  32'(ed));
        chk({tag, ".o_count"},       32'(d_count),  32'(ec));
        chk({tag, ".o_almost_full"}, 32'(d_af),     32'(eaf));
    endtask

    // Inputs change at the falling edge, the DUT samples them at the next
    // rising edge, and outputs are checked at the following falling edge.
    task automatic drive_step(input logic f, input logic v, input logic r,
                              input logic [7:0] d);
        d_flush  = f;
        d_valid  = v;
        d_iready = r;
        d_data   = d;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Random DUTs: DEPTH=2 and DEPTH=8, queue scoreboard
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_rand
        localparam int RD  = (gi == 0) ? 2 : 8;
        localparam int RCW = $clog2(RD + 1);

        logic           r_rst_n, r_valid, r_oready, r_ovalid, r_iready, r_af;
        logic [7:0]     r_data, r_odata;
        logic [RCW-1:0] r_count;
        bit             done = 1'b0;

        skid_fifo #(.DW(8), .DEPTH(RD), .AF_MARGIN(1)) u_rdut (
            .i_clk         (clk),
            .i_reset_n     (r_rst_n),
            .i_flush       (1'b0),
            .i_valid       (r_valid),
            .o_ready       (r_oready),
            .i_data        (r_data),
            .o_valid       (r_ovalid),
            .i_ready       (r_iready),
            .o_data        (r_odata),
            .o_count       (r_count),
            .o_almost_full (r_af)
        );

        initial begin
            logic [7:0] q[$];
            logic [7:0] last;
            logic [7:0] exp_data;
            logic       exp_valid, exp_ready, exp_af, acc, pop;
            int         rbias;

            last     = 8'h00;
            r_rst_n  = 1'b0;
            r_valid  = 1'b0;
            r_iready = 1'b0;
            r_data   = 8'h00;
            repeat (3) @(negedge clk);
            r_rst_n = 1'b1;

            for (int c = 0; c < 10000; c++) begin
                @(negedge clk);
                exp_valid = (q.size() > 0);
                exp_data  = exp_valid ? q[0] : last;
                exp_ready = (q.size() < RD);
                exp_af    = (q.size() >= RD - 1);
                checks++;
                if (r_ovalid !== exp_valid || r_oready !== exp_ready ||
                    r_count !== RCW'(q.size()) || r_odata !== exp_data ||
                    r_af !== exp_af || int'(r_count) > RD) begin
                    errs++;
                    $display("FAIL rand_depth%0d cycle %0d: got v=%b r=%b cnt=%0d d=%h af=%b expected v=%b r=%b cnt=%0d d=%h af=%b",
                             RD, c, r_ovalid, r_oready, r_count, r_odata, r_af,
                             exp_valid, exp_ready, q.size(), exp_data, exp_af);
                end

                // Alternate drain-heavy and fill-heavy phases so the buffer
                // regularly reaches both empty and full.
                rbias    = ((c % 2000) < 1000) ? 80 : 30;
                r_iready = ($urandom_range(0, 99) < rbias);
                r_valid  = ($urandom_range(0, 99) < 70);
                r_data   = 8'($urandom);

                acc = r_valid && (q.size() < RD);
                pop = (q.size() > 0) && r_iready;
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(r_data);
                if (q.size() > 0) last = q[0];
            end
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        // Reset with live-looking inputs: they must be ignored.
        d_rst_n  = 1'b0;
        d_flush  = 1'b0;
        d_valid  = 1'b1;
        d_iready = 1'b1;
        d_data   = 8'hFF;
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

        d_rst_n = 1'b1;
        d_valid = 1'b0;
        @(negedge clk);
        check_all("release", 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);

        // Streaming: one word per cycle, one cycle latency, count stays 1.
        for (int i = 1; i <= 16; i++) begin
            drive_step(1'b0, 1'b1, 1'b1, 8'(i));
            check_all("stream", 1'b1, 1'b1, 8'(i), 3'd1, 1'b0);
        end
        drive_step(1'b0, 1'b0, 1'b1, 8'h00);
        check_all("stream_end", 1'b0, 1'b1, 8'h10, 3'd0, 1'b0);

        //                f     v     r     data    ev    er    ed      ec    eaf
        // Fill under stall, blocked word, drain.
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA0,  1'b1, 1'b1, 8'hA0,  3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA1,  1'b1, 1'b1, 8'hA0,  3'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA2,  1'b1, 1'b1, 8'hA0,  3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA3,  1'b1, 1'b0, 8'hA0,  3'd4, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA4,  1'b1, 1'b0, 8'hA0,  3'd4, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 8'hA1,  3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 8'hA2,  3'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 8'hA3,  3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b0, 1'b1, 8'hA3,  3'd0, 1'b0));
        // Full, then valid+ready together: ready returns on the pop edge.
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hB0,  1'b1, 1'b1, 8'hB0,  3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hB1,  1'b1, 1'b1, 8'hB0,  3'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hB2,  1'b1, 1'b1, 8'hB0,  3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hB3,  1'b1, 1'b0, 8'hB0,  3'd4, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hB4,  1'b1, 1'b1, 8'hB1,  3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hB4,  1'b1, 1'b1, 8'hB2,  3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hB5,  1'b1, 1'b1, 8'hB3,  3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 8'hB4,  3'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 8'hB5,  3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b0, 1'b1, 8'hB5,  3'd0, 1'b0));
        // Flush at count 3 with a simultaneous accept of 0x55.
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC0,  1'b1, 1'b1, 8'hC0,  3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC1,  1'b1, 1'b1, 8'hC0,  3'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC2,  1'b1, 1'b1, 8'hC0,  3'd3, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h55,  1'b0, 1'b1, 8'hC0,  3'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b0, 1'b1, 8'hC0,  3'd0, 1'b0));
        // Reuse after flush: pointers restart cleanly.
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hD0,  1'b1, 1'b1, 8'hD0,  3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00,  1'b0, 1'b1, 8'hD0,  3'd0, 1'b0));

        for (int k = 0; k < vecs.size(); k++) begin
            drive_step(vecs[k].flush, vecs[k].valid, vecs[k].ready, vecs[k].data);
            check_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].er,
                      vecs[k].ed, vecs[k].ec, vecs[k].eaf);
        end
        d_valid  = 1'b0;
        d_iready = 1'b0;

        // Wait, bounded, for both random runs to finish.
        for (int t = 0; t < 15000 && !(g_rand[0].done && g_rand[1].done); t++) begin
            @(negedge clk);
        end
        checks++;
        if (!(g_rand[0].done && g_rand[1].done)) begin
            errs++;
            $display("FAIL rand_timeout: got done=%b%b expected 11",
                     g_rand[1].done, g_rand[0].done);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_skid_fifo
`default_nettype wire
